// File: rtl/fetch_ctrl_if.sv
// Signal bundle of fetch_ctrl: fetch-stage address/data, redirect request and
// the decode-side queue head handshake.
interface fetch_ctrl_if;
    logic [31:0] pc;
    logic [31:0] instA;
    logic [31:0] instB;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instA;
    logic [31:0] out_instB;
    logic [31:0] out_pc;
    logic        out_validB;
    logic        done;

    modport master (
        output pc, out_valid, out_instA, out_instB, out_pc, out_validB, done,
        input  instA, instB, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  pc, out_valid, out_instA, out_instB, out_pc, out_validB, done,
        output instA, instB, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-pair fetch controller: credit-based issue, a QDEPTH-entry pair
// queue toward decode, end-of-program detection and redirect/flush.
module fetch_ctrl #(
    parameter int unsigned QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic          clk,
    input logic          rst_n,
    fetch_ctrl_if.master bus
);
    localparam int unsigned PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW:0] DEPTH = (PW + 1)'(QDEPTH);

    typedef enum logic {
        S_FETCH,
        S_END
    } state_t;

    typedef struct packed {
        logic        valid_b;
        logic [31:0] pc;
        logic [31:0] inst_a;
        logic [31:0] inst_b;
    } entry_t;

    state_t        state;
    logic [31:0]   pc_q;
    logic [31:0]   issue_pc;
    logic          inflight;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    entry_t        mem [QDEPTH];

    entry_t        head;
    logic [PW:0]   used;
    logic          out_valid;
    logic          issue;
    logic          ret_live;
    logic          push;
    logic          pop;

    // NOTE: combinational logic uses blocking '=' and assigns every signal a
    // default first, so no path through the block can infer a latch.
    always_comb begin
        used      = '0;
        out_valid = 1'b0;
        issue     = 1'b0;
        ret_live  = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;

        used      = count + {{PW{1'b0}}, inflight};
        out_valid = (count != '0);
        issue     = (state == S_FETCH) && (used < DEPTH) && !bus.redirect_valid;
        // Returned data only matters while still fetching; a redirect drops it.
        ret_live  = inflight && (state == S_FETCH) && !bus.redirect_valid;
        push      = ret_live && (bus.instA != '0);
        pop       = out_valid && bus.out_ready;
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc_q     <= RESET_PC;
            issue_pc <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect_valid) begin
            state    <= S_FETCH;
            pc_q     <= {bus.redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                issue_pc <= pc_q;
                pc_q     <= pc_q + 32'd8;
            end
            if (ret_live && (bus.instA == '0)) begin
                state <= S_END;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage has no reset; a slot is only read once count says it
    // was written, and the head outputs are masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{valid_b: (bus.instB != '0),
                             pc:      issue_pc,
                             inst_a:  bus.instA,
                             inst_b:  bus.instB};
        end
    end

    assign head           = mem[rd_ptr];
    assign bus.pc         = pc_q;
    assign bus.out_valid  = out_valid;
    assign bus.out_instA  = out_valid ? head.inst_a : '0;
    assign bus.out_instB  = out_valid ? head.inst_b : '0;
    assign bus.out_pc     = out_valid ? head.pc : '0;
    assign bus.out_validB = out_valid && head.valid_b;
    assign bus.done       = (state == S_END) && (count == '0) && !inflight;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a ROM model answers fetches and a
// program-order scoreboard predicts every beat handed to decode.
module tb_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
    } beat_t;

    logic clk;
    logic rst_n;
    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .QDEPTH   (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_err;
    int          cyc;
    logic [31:0] rom [64];
    beat_t       exp_q [$];

    bit           hold_pending;
    logic [127:0] hold_val;
    int           beat_n;
    int           first_beat_cyc;
    int           last_beat_cyc;
    logic [31:0]  first_pc;
    logic [31:0]  last_pc;
    logic         last_vb;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_rd(input logic [31:0] a);
        return rom[a[7:2]];
    endfunction

    // Program order: pairs from the start address until a pair whose first word is zero.
    task automatic build_expect(input logic [31:0] start);
        logic [31:0] a;
        exp_q.delete();
        a = start & ~32'd3;
        for (int k = 0; k < 40; k++) begin
            if (rom_rd(a) == 32'd0) break;
            exp_q.push_back('{pc: a, a: rom_rd(a), b: rom_rd(a + 32'd4)});
            a = a + 32'd8;
        end
    endtask

    task automatic fill_prefix(input int n);
        for (int i = 0; i < 64; i++) rom[i] = (i < n) ? ($urandom | 32'd1) : 32'd0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) rom[i] = ($urandom_range(7) == 0) ? 32'd0 : ($urandom | 32'd1);
        rom[62] = 32'd0;
        rom[63] = 32'd0;
    endtask

    task automatic clear_stats();
        beat_n = 0;
        first_beat_cyc = 0;
        last_beat_cyc = 0;
        first_pc = '0;
        last_pc = '0;
        last_vb = 1'b0;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
        logic [31:0] p;
        beat_t e;
        bus.out_ready      = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        if (hold_pending)
            check("hold", {bus.out_valid, bus.out_validB, bus.out_pc, bus.out_instA, bus.out_instB}, hold_val);
        hold_pending = bus.out_valid && !rdy && !redir;
        hold_val = {1'b1, bus.out_validB, bus.out_pc, bus.out_instA, bus.out_instB};
        if (bus.out_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("beat_pc", bus.out_pc, e.pc);
                check("beat_a", bus.out_instA, e.a);
                check("beat_b", bus.out_instB, e.b);
                check("beat_vb", bus.out_validB, e.b != 32'd0);
            end
            if (beat_n == 0) begin
                first_beat_cyc = cyc;
                first_pc = bus.out_pc;
            end
            last_beat_cyc = cyc;
            last_pc = bus.out_pc;
            last_vb = bus.out_validB;
            beat_n++;
        end
        if (bus.done) check("done_q", exp_q.size(), 0);
        p = bus.pc;
        @(posedge clk);
        #1;
        bus.instA = rom_rd(p);
        bus.instB = rom_rd(p + 32'd4);
        bus.redirect_valid = 1'b0;
        if (redir) build_expect(rpc);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_done(input int budget, input int prob, input int max_redir);
        int  nred;
        bit  rdy;
        bit  redir;
        nred = 0;
        for (int i = 0; i < budget && !bus.done; i++) begin
            rdy = ($urandom_range(99) < prob);
            redir = 1'b0;
            if (nred < max_redir && $urandom_range(39) == 0) begin
                redir = 1'b1;
                nred++;
            end
            step(rdy, redir, 32'($urandom_range(255)));
        end
        check("done", bus.done, 1'b1);
        check("drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        hold_pending = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        hold_pending = 1'b0;
        bus.instA = '0;
        bus.instB = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        fill_prefix(8);
        @(negedge clk);
        @(negedge clk);

        // Values held in reset
        check("rst_pc", bus.pc, RESET_PC);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_vb", bus.out_validB, 1'b0);
        check("rst_a", bus.out_instA, 32'd0);
        check("rst_b", bus.out_instB, 32'd0);
        check("rst_opc", bus.out_pc, 32'd0);
        check("rst_done", bus.done, 1'b0);

        // Streaming with decode always ready
        clear_stats();
        build_expect(RESET_PC);
        rst_n = 1'b1;
        step(1'b1, 1'b0, '0);
        check("first_issue_pc", bus.pc, RESET_PC + 32'd8);
        run_until_done(60, 100, 0);
        check("stream_beats", beat_n, 4);
        check("stream_span", last_beat_cyc - first_beat_cyc, 3);

        // Backpressure: queue fills, issue stalls, order preserved
        do_reset();
        clear_stats();
        build_expect(RESET_PC);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
        check("bp_pc", bus.pc, 32'd32);
        check("bp_valid", bus.out_valid, 1'b1);
        check("bp_head", bus.out_pc, 32'd0);
        run_until_done(60, 100, 0);
        check("bp_beats", beat_n, 4);

        // Odd-length program ends on a half pair
        fill_prefix(5);
        do_reset();
        clear_stats();
        build_expect(RESET_PC);
        run_until_done(60, 100, 0);
        check("odd_last_pc", last_pc, 32'd16);
        check("odd_last_vb", last_vb, 1'b0);

        // Redirect with three queued and one in flight
        fill_prefix(32);
        do_reset();
        clear_stats();
        build_expect(RESET_PC);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h43);
        check("redir_flush", bus.out_valid, 1'b0);
        run_until_done(80, 100, 0);
        check("redir_first_pc", first_pc, 32'h40);

        // Redirect out of the end state
        clear_stats();
        step(1'b1, 1'b1, 32'h0);
        check("end_redir_done", bus.done, 1'b0);
        run_until_done(80, 100, 0);
        check("end_redir_first", first_pc, 32'd0);
        check("end_redir_beats", beat_n, 16);

        // Reset pulse mid-stream with two entries queued
        do_reset();
        build_expect(RESET_PC);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
        check("mid_valid_pre", bus.out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_pc", bus.pc, RESET_PC);
        hold_pending = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        build_expect(RESET_PC);
        run_until_done(80, 100, 0);
        check("mid_first_pc", first_pc, RESET_PC);

        // Random programs, random decode stalls, random redirects
        for (int r = 0; r < 24; r++) begin
            fill_random();
            step(1'b1, 1'b1, 32'($urandom_range(255)));
            run_until_done(700, 20 + $urandom_range(80), 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, meaning instruction-pair queue depth (power of 2, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning first fetch address after reset.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pc, output, 32, fetch address driven to the fetch stage.
REQ-006 SHALL have ports instA and instB, input, 32 each, pair returned by fetch one cycle after pc is sampled.
REQ-007 SHALL have port redirect_valid, input, 1, branch/flush request.
REQ-008 SHALL have port redirect_pc, input, 32, new fetch target.
REQ-009 SHALL have port out_valid, output, 1, queue head valid toward decode.
REQ-010 SHALL have port out_ready, input, 1, decode accepts head.
REQ-011 SHALL have ports out_instA and out_instB, output, 32 each, queue head pair.
REQ-012 SHALL have port out_pc, output, 32, address of out_instA.
REQ-013 SHALL have port out_validB, output, 1, out_instB is a real instruction.
REQ-014 SHALL have port done, output, 1, end of program reached and queue empty.

Function
REQ-015 SHALL implement states FETCH and END; the reset state is FETCH.
REQ-016 In FETCH, a fetch SHALL issue in a cycle iff count + inflight < QDEPTH and redirect_valid=0; count is queue occupancy and inflight is 1 if a fetch issued the previous cycle and was not killed.
REQ-017 On issue, pc SHALL advance by 8 at the next edge; address arithmetic is modulo 2^32.
REQ-018 An in-flight fetch SHALL return instA/instB exactly one cycle after issue; the pair SHALL be pushed with its issue address as out_pc.
REQ-019 A returned pair with instA=0 SHALL NOT be pushed; the FSM SHALL move FETCH->END and issue stops.
REQ-020 A pushed pair with instB=0 SHALL set out_validB=0, else 1.
REQ-021 Pop SHALL occur when out_valid=1 and out_ready=1; out_* SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 Simultaneous push and pop SHALL be legal at any occupancy, leaving count unchanged.
REQ-023 Pushes SHALL never overflow: the credit rule of REQ-016 guarantees a free slot.
REQ-024 redirect_valid=1 SHALL, at the next edge: clear the queue; kill inflight (its returning data is dropped); set pc to {redirect_pc[31:2],2'b00}; enter FETCH from any state.
REQ-025 A pop handshaking in the same cycle as a redirect SHALL count as consumed; redirect wins over push.
REQ-026 Fetching SHALL resume the cycle after the redirect edge at the new pc.
REQ-027 done SHALL be 1 iff state=END and count=0 and inflight=0.
REQ-028 Queue pointers SHALL wrap modulo QDEPTH; count SHALL span 0..QDEPTH.
REQ-029 All outputs SHALL be registered or decoded from registered state only; no combinational path from out_ready or redirect_valid to any output.

Reset
REQ-030 While rst_n=0, the block SHALL hold: pc=RESET_PC, state=FETCH, count=0, inflight=0, out_valid=0, out_validB=0, out_instA=out_instB=0, out_pc=0, done=0.
REQ-031 Deassertion SHALL allow the first issue on the first rising edge with rst_n=1; assertion mid-operation SHALL discard the queue and any in-flight data immediately.

Verification
REQ-032 Streaming: RESET_PC=0, ROM holds 8 nonzero words, out_ready=1 -> out_pc 0,8,16,24 in consecutive beats, all out_validB=1, then done=1.
REQ-033 Backpressure: out_ready=0 for 10 cycles -> count saturates at 4, pc stops at 32, no data lost; release yields out_pc 0..24 in order.
REQ-034 Odd end: ROM holds 5 words -> final beat out_pc=16 with out_validB=0, next pair dropped, done=1.
REQ-035 Redirect: redirect_pc=32'h43 while queue holds 3 entries and 1 in flight -> queue empties, next out_pc=32'h40, stale pair never appears.
REQ-036 Redirect from END: redirect_pc=0 after done=1 -> done falls, streaming restarts at out_pc=0.
REQ-037 Reset mid-stream: rst_n low for 1 cycle with count=2 -> out_valid=0 immediately, restart at RESET_PC.
